or1k_marocchino_wrbk_arb: RTL
=============================

OR1K_MAROCCHINO_WRBK_ARB -- requirements
Module: or1k_marocchino_wrbk_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of write-back requesters (execution units), valid range 2..8.
REQ-002 Parameter WAIT_W, default 2, SHALL set the width of each per-requester saturating wait counter.
REQ-003 cpu_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 cpu_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pipeline_flush_i  input  1  SHALL be the pipeline flush: clears in-flight write-back state.
REQ-006 wrbk_stall_i  input  1  SHALL be the write-back stage hold: no advance while high.
REQ-007 req_valid_i  input  N_REQ  SHALL carry the per-unit result-ready flags (e.g. mul_valid_o of the integer multiplier).
REQ-008 padv_wrbk_o  output  1  SHALL be the write-back advance strobe (combinational), delivered to every unit.
REQ-009 grant_wrbk_o  output  N_REQ  SHALL be the one-hot write-back grant (combinational), bit i to unit i.
REQ-010 wrbk_valid_o  output  1  SHALL be the registered flag: the write-back register holds a result this cycle.
REQ-011 wrbk_unit_o  output  3  SHALL be the registered index of the unit whose result is in write-back.

Function
REQ-012 Any request SHALL exist iff |req_valid_i == 1.
REQ-013 padv_wrbk_o SHALL be 1 iff any request & ~wrbk_stall_i & ~pipeline_flush_i & ~cpu_rst.
REQ-014 grant_wrbk_o SHALL be all-zero whenever padv_wrbk_o == 0, and exactly one-hot otherwise.
REQ-015 Grant selection, override: if any requesting unit has a saturated wait counter (all ones), the lowest-index such unit SHALL be granted.
REQ-016 Grant selection, round-robin: otherwise, scan indices rr_ptr, rr_ptr+1, ... modulo N_REQ and grant the first requesting unit.
REQ-017 rr_ptr SHALL be an internal register, reset 0.
REQ-018 On each padv_wrbk_o cycle, rr_ptr SHALL become (granted index + 1) mod N_REQ.
REQ-019 rr_ptr SHALL be held when there is no advance and during flush.
REQ-020 Wait counters on a padv_wrbk_o cycle: the granted unit's counter SHALL clear to 0, every other requesting unit's counter SHALL increment saturating, and non-requesting units' counters SHALL clear.
REQ-021 Wait counters on a cycle with a request but no advance (stall): requesting units' counters SHALL increment saturating, and non-requesting units' counters SHALL clear.
REQ-022 Wait counters with no request: all counters SHALL clear.
REQ-023 wrbk_valid_o SHALL take the value of padv_wrbk_o registered one cycle (latency 1 from grant to write-back).
REQ-024 wrbk_unit_o SHALL load the granted index only on padv_wrbk_o cycles, otherwise hold.
REQ-025 Flush SHALL take priority over stall and requests: padv 0, grant 0, wrbk_valid_o <= 0, all wait counters <= 0, rr_ptr and wrbk_unit_o held.
REQ-026 Requester contract: a unit SHALL drop or refresh its req_valid_i only after padv_wrbk_o & grant bit; the arbiter SHALL NOT latch requests (no internal request buffering).
REQ-027 A request asserted on a stalled cycle SHALL remain eligible with no loss; simultaneous stall and flush SHALL behave as flush.

Reset
REQ-028 While cpu_rst == 1, padv_wrbk_o SHALL be 0 and grant_wrbk_o SHALL be 0.
REQ-029 On reset, wrbk_valid_o SHALL become 0, wrbk_unit_o 0, rr_ptr 0, and all wait counters 0 on the next edge.
REQ-030 Reset asserted mid-stream SHALL drop any pending grant; with requests still present after deassertion, the first grant SHALL start from index 0.

Verification
REQ-031 Round-robin: N_REQ=4, req_valid_i=4'b1111 held, no stall -> grants one-hot 0,1,2,3,0 on consecutive cycles; wrbk_unit_o lags by 1 cycle.
REQ-032 Stall: req_valid_i=4'b0100, wrbk_stall_i high 5 cycles -> padv 0, grant 0000 throughout; on release, grant 0100 that cycle, wrbk_valid_o=1 next cycle with wrbk_unit_o=2.
REQ-033 Saturation override: rr_ptr=3, req_valid_i=4'b1010, stall 4 cycles (both counters reach 3) -> on release, grant 0010 (unit 1, lowest saturated) and not unit 3.
REQ-034 Flush: req_valid_i=4'b0011 with pipeline_flush_i=1 for 1 cycle -> padv 0, grant 0000, wrbk_valid_o=0 next cycle, rr_ptr unchanged.
REQ-035 Reset mid-operation: grants flowing with rr_ptr=2, cpu_rst=1 for 1 cycle, then req_valid_i=4'b1111 -> first grant 0001.
REQ-036 Single requester: req_valid_i=4'b1000, no stall -> grant 1000 every cycle, rr_ptr=0 after each advance, wrbk_valid_o steady 1.

Source files
------------

// File: rtl/or1k_marocchino_wrbk_arb_if.sv
// rtl/or1k_marocchino_wrbk_arb_if.sv - write-back arbitration bus between execution units and the arbiter
interface or1k_marocchino_wrbk_arb_if #(
    parameter int N_REQ = 4
);
    logic             pipeline_flush_i;
    logic             wrbk_stall_i;
    logic [N_REQ-1:0] req_valid_i;
    logic             padv_wrbk_o;
    logic [N_REQ-1:0] grant_wrbk_o;
    logic             wrbk_valid_o;
    logic [2:0]       wrbk_unit_o;

    modport master (
        output pipeline_flush_i, wrbk_stall_i, req_valid_i,
        input  padv_wrbk_o, grant_wrbk_o, wrbk_valid_o, wrbk_unit_o
    );

    modport slave (
        input  pipeline_flush_i, wrbk_stall_i, req_valid_i,
        output padv_wrbk_o, grant_wrbk_o, wrbk_valid_o, wrbk_unit_o
    );
endinterface

// File: rtl/or1k_marocchino_wrbk_arb.sv
// rtl/or1k_marocchino_wrbk_arb.sv - round-robin write-back arbiter with starvation override
module or1k_marocchino_wrbk_arb #(
    parameter int N_REQ  = 4,
    parameter int WAIT_W = 2
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst,
    or1k_marocchino_wrbk_arb_if.slave     bus
);

    logic [WAIT_W-1:0] r_wait [N_REQ];
    logic [2:0]        r_rr_ptr;
    logic [2:0]        r_unit;
    logic              r_wrbk_valid;

    logic              w_any_req;
    logic              w_padv;
    logic              w_sat_found;
    logic [2:0]        w_sat_idx;
    logic [2:0]        w_rr_idx;
    logic [2:0]        w_gnt_idx;
    logic [N_REQ-1:0]  w_grant;
    int                w_dist;
    int                w_best_dist;

    assign w_any_req = |bus.req_valid_i;
    assign w_padv    = w_any_req & ~bus.wrbk_stall_i & ~bus.pipeline_flush_i & ~cpu_rst;

    // Starved units win outright; otherwise pick the requester nearest rr_ptr in scan order.
    always_comb begin
        w_sat_found = 1'b0;
        w_sat_idx   = 3'd0;
        w_rr_idx    = 3'd0;
        w_dist      = 0;
        w_best_dist = N_REQ;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_i[i] && (&r_wait[i])) begin
                w_sat_found = 1'b1;
                w_sat_idx   = 3'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - int'(r_rr_ptr)) % N_REQ;
            if (bus.req_valid_i[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_rr_idx    = 3'(i);
            end
        end
        w_gnt_idx = w_sat_found ? w_sat_idx : w_rr_idx;
        w_grant   = '0;
        if (w_padv) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_wrbk_valid <= 1'b0;
            r_unit       <= 3'd0;
            r_rr_ptr     <= 3'd0;
            for (int i = 0; i < N_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else if (bus.pipeline_flush_i) begin
            r_wrbk_valid <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_wrbk_valid <= w_padv;
            if (w_padv) begin
                r_unit   <= w_gnt_idx;
                r_rr_ptr <= (w_gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_valid_i[i] || (w_padv && (w_gnt_idx == 3'(i)))) begin
                    r_wait[i] <= '0;
                end else if (!(&r_wait[i])) begin
                    r_wait[i] <= r_wait[i] + WAIT_W'(1);
                end
            end
        end
    end

    assign bus.padv_wrbk_o  = w_padv;
    assign bus.grant_wrbk_o = w_grant;
    assign bus.wrbk_valid_o = r_wrbk_valid;
    assign bus.wrbk_unit_o  = r_unit;

endmodule
